// File: rtl/pwm_duty_ramp_if.sv
// pwm_duty_ramp_if: command, abort and duty/status bundle for the duty ramp sequencer
interface pwm_duty_ramp_if #(
    parameter int BIT_WIDTH = 3,
    parameter int IVL_WIDTH = 8
);
    logic [BIT_WIDTH-1:0] max_value;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [BIT_WIDTH-1:0] cmd_target;
    logic [BIT_WIDTH-1:0] cmd_step;
    logic [IVL_WIDTH-1:0] cmd_interval;
    logic                 abort;
    logic [BIT_WIDTH-1:0] duty;
    logic                 busy;
    logic                 done;
    modport master (
        output max_value, cmd_valid, cmd_target, cmd_step, cmd_interval, abort,
        input  cmd_ready, duty, busy, done
    );
    modport slave (
        input  max_value, cmd_valid, cmd_target, cmd_step, cmd_interval, abort,
        output cmd_ready, duty, busy, done
    );
endinterface

// File: rtl/pwm_duty_ramp.sv
// pwm_duty_ramp: walks a PWM duty value toward a commanded target,
// changing it only on PWM period boundaries.
module pwm_duty_ramp #(
    parameter int BIT_WIDTH = 3,
    parameter int IVL_WIDTH = 8
) (
    input logic clk,
    input logic rst_n,
    pwm_duty_ramp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
    state_t               state;
    logic [BIT_WIDTH-1:0] pcnt, duty, tgt, stp, cmd_tgt, cmd_stp, nxt;
    logic [IVL_WIDTH-1:0] ivl, icnt;
    logic [BIT_WIDTH:0]   sum, diff;
    logic                 tick, done;
    assign tick    = pcnt == bus.max_value;
    assign cmd_tgt = bus.cmd_target > bus.max_value ? bus.max_value : bus.cmd_target;
    assign cmd_stp = bus.cmd_step == '0 ? {{(BIT_WIDTH-1){1'b0}}, 1'b1} : bus.cmd_step;
    assign sum     = {1'b0, duty} + {1'b0, stp};
    assign diff    = {1'b0, duty} - {1'b0, stp};
    // one extra bit catches both overflow past the top and underflow below 0
    always_comb begin
        nxt = state == UP ? (sum > {1'b0, tgt} ? tgt : sum[BIT_WIDTH-1:0])
                          : (diff[BIT_WIDTH] || diff[BIT_WIDTH-1:0] < tgt ? tgt : diff[BIT_WIDTH-1:0]);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pcnt <= '0;
        else
            pcnt <= pcnt >= bus.max_value ? '0 : pcnt + 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            duty  <= '0;
            done  <= 1'b0;
            tgt   <= '0;
            stp   <= '0;
            ivl   <= '0;
            icnt  <= '0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (bus.cmd_valid) begin
                    tgt   <= cmd_tgt;
                    stp   <= cmd_stp;
                    ivl   <= bus.cmd_interval;
                    icnt  <= '0;
                    state <= cmd_tgt > duty ? UP : cmd_tgt < duty ? DOWN : IDLE;
                    done  <= cmd_tgt == duty;
                end
            end else begin
                if (tick) begin
                    if (icnt == ivl) begin
                        duty <= nxt;
                        icnt <= '0;
                        if (nxt == tgt) begin
                            state <= IDLE;
                            done  <= !bus.abort;
                        end
                    end else
                        icnt <= icnt + 1'b1;
                end
                // abort overrides completion: duty may still land on target, but no done
                if (bus.abort)
                    state <= IDLE;
            end
        end
    end
    assign bus.duty      = duty;
    assign bus.done      = done;
    assign bus.cmd_ready = state == IDLE;
    assign bus.busy      = state != IDLE;
endmodule
